// File: rtl/ram_bus_arbiter.sv
// Round-robin arbiter sharing one RAM controller port between NUM_REQ requesters,
// with an optional burst lock and a busy-handshake timeout.
module ram_bus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TW             = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_lock,
  input  logic [NUM_REQ*23-1:0] req_addr,
  input  logic [NUM_REQ*16-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]   req_instr,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic [15:0]          rdata,
  output logic                 timeout_err,
  output logic [23:1]          ramBusAddr,
  output logic [15:0]          ramBusDataIn,
  output logic                 ramInstruction,
  output logic                 ramLatch,
  input  logic                 ramReady,
  input  logic [15:0]          ramBusDataOut
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state_reg;
  logic [IW-1:0]   owner_reg;
  logic [IW-1:0]   rr_ptr_reg;
  logic [IW-1:0]   lock_owner_reg;
  logic            lock_valid_reg;
  logic [TW-1:0]   tmo_cnt_reg;

  logic [22:0]     addr_arr  [NUM_REQ];
  logic [15:0]     wdata_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[23*gi +: 23];
      assign wdata_arr[gi] = req_wdata[16*gi +: 16];
    end
  endgenerate

  logic [IW-1:0] win_idx;
  logic          win_valid;

  // Scan from farthest to nearest so the requester closest after rr_ptr ends up winning.
  always_comb begin
    int idx;
    win_idx   = '0;
    win_valid = 1'b0;
    idx       = 0;
    if (lock_valid_reg && req[lock_owner_reg]) begin
      win_idx   = lock_owner_reg;
      win_valid = 1'b1;
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        idx = int'(rr_ptr_reg) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (req[IW'(idx)]) begin
          win_idx   = IW'(idx);
          win_valid = 1'b1;
        end
      end
    end
  end

  logic finish;
  logic timed_out;

  assign timed_out = (state_reg == WAIT_BUSY) && ramReady &&
                     (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
  assign finish    = timed_out || ((state_reg == WAIT_DONE) && ramReady);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      rr_ptr_reg     <= IW'(NUM_REQ - 1);
      lock_owner_reg <= '0;
      lock_valid_reg <= 1'b0;
      tmo_cnt_reg    <= '0;
      grant          <= '0;
      done           <= '0;
      rdata          <= '0;
      timeout_err    <= 1'b0;
      ramBusAddr     <= '0;
      ramBusDataIn   <= '0;
      ramInstruction <= 1'b0;
      ramLatch       <= 1'b0;
    end else begin
      done        <= '0;
      timeout_err <= 1'b0;
      ramLatch    <= 1'b0;

      case (state_reg)
        IDLE: begin
          // The done cycle keeps grant visible to the owner; arbitration waits one cycle.
          if (|done) begin
            grant <= '0;
          end else begin
            if (lock_valid_reg && !req[lock_owner_reg]) lock_valid_reg <= 1'b0;
            if (ramReady && win_valid) begin
              owner_reg      <= win_idx;
              grant          <= NUM_REQ'(1) << win_idx;
              ramBusAddr     <= addr_arr[win_idx];
              ramBusDataIn   <= wdata_arr[win_idx];
              ramInstruction <= req_instr[win_idx];
              state_reg      <= ISSUE;
            end else begin
              grant <= '0;
            end
          end
        end
        ISSUE: begin
          ramLatch    <= 1'b1;
          tmo_cnt_reg <= '0;
          state_reg   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!ramReady)       state_reg   <= WAIT_DONE;
          else if (!timed_out) tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
        end
        WAIT_DONE: begin
          if (ramReady) rdata <= ramBusDataOut;
        end
        default: state_reg <= IDLE;
      endcase

      if (finish) begin
        done           <= NUM_REQ'(1) << owner_reg;
        timeout_err    <= timed_out;
        rr_ptr_reg     <= owner_reg;
        lock_owner_reg <= owner_reg;
        lock_valid_reg <= req_lock[owner_reg];
        state_reg      <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter: vector table plus hand sequences for timeout and reset.
module tb_ram_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, req_lock, req_instr;
  logic [45:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  grant, done;
  logic [15:0] rdata;
  logic        timeout_err;
  logic [23:1] ramBusAddr;
  logic [15:0] ramBusDataIn;
  logic        ramInstruction, ramLatch;
  logic        ramReady;
  logic [15:0] ramBusDataOut;

  ram_bus_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(255), .TW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_lock(req_lock), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_instr(req_instr), .grant(grant), .done(done),
    .rdata(rdata), .timeout_err(timeout_err), .ramBusAddr(ramBusAddr),
    .ramBusDataIn(ramBusDataIn), .ramInstruction(ramInstruction), .ramLatch(ramLatch),
    .ramReady(ramReady), .ramBusDataOut(ramBusDataOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  lock;
    logic        instr;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [15:0] rd;
    logic [1:0]  exp_grant;
  } vec_t;

  vec_t tbl [11];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Winner gets the row's fields; the other requester gets distinct values.
  task automatic drive_row(input vec_t v);
    req      = v.req;
    req_lock = v.lock;
    for (int i = 0; i < 2; i++) begin
      req_addr[23*i +: 23]  = v.exp_grant[i] ? v.addr  : v.addr ^ 23'h155555;
      req_wdata[16*i +: 16] = v.exp_grant[i] ? v.wdata : ~v.wdata;
      req_instr[i]          = v.exp_grant[i] ? v.instr : ~v.instr;
    end
  endtask

  // Plays the RAM controller for one normal transaction.
  task automatic serve(input logic [15:0] rd, input logic [22:0] ea, input logic [15:0] ew,
                       input logic ei, output logic [1:0] g, output logic [1:0] d);
    int n;
    n = 0;
    while (ramLatch !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("latch_seen", 32'(n < 40), 1);
    g = grant;
    chk("addr_at_latch", ramBusAddr, ea);
    chk("wdata_at_latch", ramBusDataIn, ew);
    chk("instr_at_latch", ramInstruction, ei);
    req_addr  = ~req_addr;
    req_wdata = ~req_wdata;
    @(negedge clk);
    ramReady = 1'b0;
    chk("latch_width", ramLatch, 0);
    repeat (3) @(negedge clk);
    ramReady      = 1'b1;
    ramBusDataOut = rd;
    n = 0;
    do begin @(negedge clk); n++; end while (done == 2'b00 && n < 10);
    d = done;
    chk("done_seen", 32'(n < 10), 1);
    chk("timeout_err_normal", timeout_err, 0);
    chk("rdata", rdata, rd);
    chk("grant_held_in_done", grant, g);
    chk("addr_held", ramBusAddr, ea);
    $display("txn: grant=%b done=%b rdata=%h addr=%h", g, d, rdata, ramBusAddr);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("no_same_cycle_regrant", grant, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  g, d;
    logic [15:0] prev;
    int          n;

    tbl[0]  = '{2'b11, 2'b00, 1'b0, 23'h000100, 16'h1111, 16'hA001, 2'b01};
    tbl[1]  = '{2'b11, 2'b00, 1'b0, 23'h000200, 16'h2222, 16'hA002, 2'b10};
    tbl[2]  = '{2'b11, 2'b00, 1'b0, 23'h000300, 16'h3333, 16'hA003, 2'b01};
    tbl[3]  = '{2'b11, 2'b00, 1'b0, 23'h000400, 16'h4444, 16'hA004, 2'b10};
    tbl[4]  = '{2'b11, 2'b01, 1'b0, 23'h001000, 16'h0001, 16'hB001, 2'b01};
    tbl[5]  = '{2'b11, 2'b01, 1'b1, 23'h001001, 16'h0002, 16'hB002, 2'b01};
    tbl[6]  = '{2'b11, 2'b01, 1'b0, 23'h001002, 16'h0003, 16'hB003, 2'b01};
    tbl[7]  = '{2'b11, 2'b01, 1'b1, 23'h001003, 16'h0004, 16'hB004, 2'b01};
    tbl[8]  = '{2'b11, 2'b00, 1'b0, 23'h001004, 16'h0005, 16'hB005, 2'b01};
    tbl[9]  = '{2'b11, 2'b00, 1'b0, 23'h002000, 16'h0006, 16'hB006, 2'b10};
    tbl[10] = '{2'b10, 2'b00, 1'b1, 23'h7FFFFF, 16'h1234, 16'hC0DE, 2'b10};

    rst = 1'b1; req = '0; req_lock = '0; req_instr = '0; req_addr = '0; req_wdata = '0;
    ramReady = 1'b1; ramBusDataOut = '0;
    repeat (2) @(negedge clk);
    chk("reset_grant", grant, 0);
    chk("reset_done", done, 0);
    chk("reset_latch", ramLatch, 0);
    chk("reset_rdata", rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single read: req 0 wins first, latch two cycles after request.
    req = 2'b01; req_instr = 2'b00; req_addr[22:0] = 23'h000005; req_addr[45:23] = 23'h0000AA;
    n = 0;
    while (ramLatch !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk("latch_latency", n, 2);
    serve(16'hBEEF, 23'h000005, 16'h0000, 1'b0, g, d);
    req = 2'b00;
    chk("single_grant", g, 2'b01);
    chk("single_done", d, 2'b01);

    rst = 1'b1; @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive_row(tbl[i]);
      serve(tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].instr, g, d);
      chk($sformatf("row%0d_grant", i), g, tbl[i].exp_grant);
      chk($sformatf("row%0d_done", i), d, tbl[i].exp_grant);
    end
    req = 2'b00; req_lock = 2'b00;
    @(negedge clk);

    // Timeout: controller never goes busy.
    prev = rdata;
    req = 2'b01; req_addr[22:0] = 23'h000042;
    n = 0;
    while (ramLatch !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk("tmo_latch_seen", 32'(n < 10), 1);
    n = 0;
    do begin @(negedge clk); n++; end while (done == 2'b00 && n < 300);
    req = 2'b00;
    chk("tmo_cycles", n, 255);
    chk("tmo_done", done, 2'b01);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_rdata_kept", rdata, prev);
    $display("txn: timeout after %0d cycles done=%b err=%b", n, done, timeout_err);
    @(negedge clk);
    chk("tmo_err_one_cycle", timeout_err, 0);
    req = 2'b01; req_addr[22:0] = 23'h000043; req_instr[0] = 1'b0;
    serve(16'h5A5A, 23'h000043, req_wdata[15:0], 1'b0, g, d);
    req = 2'b00;
    chk("after_tmo_done", d, 2'b01);

    // Reset while waiting for the controller to finish.
    req = 2'b01; req_addr[22:0] = 23'h0ABCDE; req_wdata[15:0] = 16'h7777;
    n = 0;
    while (ramLatch !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    @(negedge clk); ramReady = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; req = 2'b00;
    @(negedge clk);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_latch", ramLatch, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_addr", ramBusAddr, 0);
    chk("mid_rst_wdata", ramBusDataIn, 0);
    chk("mid_rst_err", timeout_err, 0);
    rst = 1'b0; ramReady = 1'b1;
    @(negedge clk);
    chk("post_rst_no_done_a", done, 0);
    @(negedge clk);
    chk("post_rst_no_done_b", done, 0);
    req = 2'b10; req_addr[45:23] = 23'h012345; req_wdata[31:16] = 16'h9999; req_instr[1] = 1'b0;
    serve(16'h0F0F, 23'h012345, 16'h9999, 1'b0, g, d);
    req = 2'b00;
    chk("post_rst_grant", g, 2'b10);
    chk("post_rst_done", d, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Shares the single external RAM controller port between NUM_REQ requesters, e.g. req 0 = network DNA loader, req 1 = GA DNA writer, req 2 = fitness logger.
- Round-robin arbitration with an optional per-requester lock for bursts, such as a full genome load.
- Issues one latch per transaction, tracks the ramReady busy/done handshake and returns read data.
- Sits between the network/population logic and the RAM controller.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- TIMEOUT_CYCLES, 255, maximum cycles to wait for ramReady to fall after a latch before aborting.
- TW, 8, width of the timeout counter; must satisfy 2^TW > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester transaction request; hold high until grant bit seen.
- req_lock  in  NUM_REQ  per-requester burst lock, sampled at done.
- req_addr  in  NUM_REQ*23  per-requester word address; requester i uses bits [23*i+22:23*i].
- req_wdata  in  NUM_REQ*16  per-requester write data.
- req_instr  in  NUM_REQ  per-requester opcode: 0 = READ, 1 = WRITE.
- grant  out  NUM_REQ  one-hot owner, held from selection through the done cycle.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rdata  out  16  read data; valid in the done cycle and held until the next capture.
- timeout_err  out  1  one-cycle pulse, coincident with done, when a transaction aborts.
- ramBusAddr  out  [23:1]  address to the RAM controller.
- ramBusDataIn  out  16  write data to the RAM controller.
- ramInstruction  out  1  opcode to the RAM controller.
- ramLatch  out  1  one-cycle transaction start strobe.
- ramReady  in  1  controller idle/complete flag: high = idle, low = busy.
- ramBusDataOut  in  16  read data from the controller.

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr = NUM_REQ-1 (so req 0 wins first), lock_owner invalid, timeout counter 0.
- Reset mid-transaction: same values apply on the next edge; ramLatch drops immediately; no done pulse is generated.

FSM:
- IDLE: if ramReady==1 and |req, select the winner.
  - If lock_owner is valid and its req is high, it wins.
  - Otherwise the first req[i] high scanning rr_ptr+1, rr_ptr+2, ... mod NUM_REQ.
  - Register the winner's addr, wdata and instr into the ram* outputs; set grant one-hot; go to ISSUE.
  - If ramReady==0 or no req, stay in IDLE with grant = 0.
- ISSUE: ramLatch=1 for exactly this cycle; clear timeout counter; go to WAIT_BUSY.
- WAIT_BUSY: ramLatch=0.
  - If ramReady==0, go to WAIT_DONE.
  - Else increment the counter; when counter == TIMEOUT_CYCLES-1, pulse done[owner] and timeout_err, leave rdata unchanged, go to IDLE.
- WAIT_DONE: when ramReady==1, set rdata = ramBusDataOut (for WRITE as well), pulse done[owner], go to IDLE.

Done cycle (normal or timeout):
- rr_ptr = owner.
- lock_owner = owner if req_lock[owner]==1, else invalid.
- grant clears on the following edge.

Timing and handshake:
- Latency from req high (bus free, ramReady high) to ramLatch: 2 cycles (grant at edge 1, latch at edge 2).
- Minimum transaction length: 4 cycles (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE).
- Address, data and opcode are captured at grant. A requester may change them, or drop req, after grant without affecting the transaction in flight.
- Dropping req before grant withdraws the request cleanly.
- ram* address/data/opcode outputs hold their last values in IDLE.
- Simultaneous done and a new req: arbitration happens in the next IDLE cycle; no same-cycle re-grant.
- Lock: a locked owner that deasserts req in IDLE releases the lock; normal round-robin resumes from rr_ptr.
- Never more than one grant bit or one done bit high.

Test Plan:
- Single read: req[0]=1, addr=0x000005, READ; controller drops ramReady 1 cycle after latch and raises it 3 cycles later with 0xBEEF -> ramLatch high exactly 1 cycle, 2 cycles after req; rdata=0xBEEF; done=2'b01 for one cycle.
- Round-robin: req=2'b11 held for 4 transactions -> grant order 0,1,0,1; no lock asserted.
- Lock burst: req_lock[0]=1 with req=2'b11 for 5 transactions, then lock drops -> grants 0,0,0,0,0,1.
- Timeout: ramReady stays high after latch -> done[owner] and timeout_err pulse on the 255th WAIT_BUSY cycle; rdata unchanged; next request is serviced normally.
- Reset mid-operation: rst asserted during WAIT_DONE -> next edge all outputs 0, no done; after release, req[1] alone -> grant 2'b10, transaction completes.
- Write path: req[1] WRITE, addr=0x7FFFFF, wdata=0x1234 -> ramBusAddr=0x7FFFFF, ramBusDataIn=0x1234, ramInstruction=1 at the latch cycle.
